// File: rtl/ender_clock_pkg.sv
// Shared clock types, time limits and BCD/12-hour conversion helpers for the ender timekeeper.
package ender_clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  // Binary 0..99 to two packed BCD digits.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  // BCD 00-23 hour to {pm, 12-hour BCD hour}; midnight and noon both read as 12.
  function automatic logic [8:0] to_12h(input logic [7:0] hr);
    logic [4:0] h;
    logic [4:0] h12;
    h = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
    if (h == 5'd0)       h12 = 5'd12;
    else if (h > 5'd12)  h12 = h - 5'd12;
    else                 h12 = h;
    return {h >= 5'd12, bin_to_bcd(7'(h12))};
  endfunction

endpackage

// File: rtl/ender_bcd_counter.sv
// Two-digit BCD counter 00..MAX with increment, synchronous clear and wrap carry.
module ender_bcd_counter
  import ender_clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clear,
  output logic [7:0] value,
  output logic [7:0] next_c,
  output logic       carry_c
);

  localparam logic [7:0] MAX_BCD = bin_to_bcd(7'(MAX));

  bcd_digit_t tens;
  bcd_digit_t ones;

  assign tens = value[7:4];
  assign ones = value[3:0];

  // Clear beats increment; carry only on a real MAX->00 wrap.
  always_comb begin
    carry_c = inc && !clear && (value == MAX_BCD);
    next_c  = value;
    if (clear || carry_c) begin
      next_c = '0;
    end else if (inc) begin
      if (ones == 4'd9) next_c = {tens + 4'd1, 4'd0};
      else              next_c = {tens, ones + 4'd1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= '0;
    else        value <= next_c;
  end

endmodule

// File: rtl/ender_timekeeper.sv
// 24-hour BCD clock with set buttons, 12h display, alarm channels.
// Optional hourly chime pulse when built with ENDER_CHIME_EN.
module ender_timekeeper
  import ender_clock_pkg::*;
#(
  parameter  int unsigned TICKS_PER_SEC = 10_000_000,
  parameter  int unsigned NUM_ALARMS    = 2,
  localparam int unsigned IDX_W         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  hold,
  input  logic                  mode_12h,
  input  logic                  btn_min,
  input  logic                  btn_hr,
  input  logic                  alarm_wr,
  input  logic [IDX_W-1:0]      alarm_idx,
  input  logic [4:0]            alarm_hr,
  input  logic [5:0]            alarm_min,
  input  logic                  alarm_on,
  input  logic                  alarm_ack,
  output logic [7:0]            hour_bcd,
  output logic [7:0]            min_bcd,
  output logic [7:0]            sec_bcd,
  output logic                  pm,
  output logic                  sec_pulse,
  output logic [NUM_ALARMS-1:0] alarm_hit,
  output logic                  chime
);

  localparam int unsigned     PRE_W   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  logic [PRE_W-1:0] pre;
  logic             run;
  logic             tick_raw;
  logic             tick;
  logic [1:0]       min_sync;
  logic [1:0]       hr_sync;
  logic             min_prev;
  logic             hr_prev;
  logic             min_edge;
  logic             hr_edge;

  logic [7:0] sec_q, min_q, hr_q;
  logic [7:0] sec_next, min_next, hr_next;
  logic       sec_carry, min_carry, hr_carry;
  logic       min_inc, hr_inc;

  logic [4:0]            alm_hr  [NUM_ALARMS];
  logic [5:0]            alm_min [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alm_en;
  logic                  wr_ok;
  logic [NUM_ALARMS-1:0] hit_set;

  // Button synchronisers and rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_sync <= '0;
      hr_sync  <= '0;
      min_prev <= 1'b0;
      hr_prev  <= 1'b0;
    end else begin
      min_sync <= {min_sync[0], btn_min};
      hr_sync  <= {hr_sync[0], btn_hr};
      min_prev <= min_sync[1];
      hr_prev  <= hr_sync[1];
    end
  end

  assign min_edge = min_sync[1] & ~min_prev;
  assign hr_edge  = hr_sync[1] & ~hr_prev;

  assign run      = ena & ~hold;
  assign tick_raw = run && (pre == PRE_MAX);
  assign tick     = tick_raw & ~(min_edge | hr_edge);

  // Prescaler; a minute-set press restarts the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pre <= '0;
    else if (min_edge) pre <= '0;
    else if (tick_raw) pre <= '0;
    else if (run)      pre <= pre + PRE_W'(1);
  end

  assign min_inc = sec_carry | min_edge;
  assign hr_inc  = (min_carry & tick) | hr_edge;

  ender_bcd_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(tick), .clear(min_edge),
    .value(sec_q), .next_c(sec_next), .carry_c(sec_carry)
  );

  ender_bcd_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(min_inc), .clear(1'b0),
    .value(min_q), .next_c(min_next), .carry_c(min_carry)
  );

  ender_bcd_counter #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .rst_n(rst_n), .inc(hr_inc), .clear(1'b0),
    .value(hr_q), .next_c(hr_next), .carry_c(hr_carry)
  );

  logic unused_bits;
  assign unused_bits = ^{sec_next, hr_carry};

  assign sec_bcd = sec_q;
  assign min_bcd = min_q;

  always_comb begin
    {pm, hour_bcd} = {1'b0, hr_q};
    if (mode_12h) {pm, hour_bcd} = to_12h(hr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sec_pulse <= 1'b0;
    else        sec_pulse <= tick;
  end

  assign wr_ok = alarm_wr && (32'(alarm_idx) < NUM_ALARMS)
              && (alarm_hr <= 5'(HR_MAX)) && (alarm_min <= 6'(MIN_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_hr[i]  <= '0;
        alm_min[i] <= '0;
      end
      alm_en <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (IDX_W'(i) == alarm_idx) begin
          alm_hr[i]  <= alarm_hr;
          alm_min[i] <= alarm_min;
          alm_en[i]  <= alarm_on;
        end
      end
    end
  end

  // Only a counting tick that lands on hh:mm:00 fires; button sets never do.
  always_comb begin
    hit_set = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      hit_set[i] = sec_carry && alm_en[i]
                && (min_next == bin_to_bcd(7'(alm_min[i])))
                && (hr_next  == bin_to_bcd(7'(alm_hr[i])));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_hit <= '0;
    else        alarm_hit <= (alarm_ack ? '0 : alarm_hit) | hit_set;
  end

`ifdef ENDER_CHIME_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chime <= 1'b0;
    else        chime <= min_carry & tick;
  end
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_ender_timekeeper.sv
// Directed self-checking bench for ender_timekeeper with TICKS_PER_SEC=4, two alarms.
module tb_ender_timekeeper;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       hold;
  logic       mode_12h;
  logic       btn_min;
  logic       btn_hr;
  logic       alarm_wr;
  logic [0:0] alarm_idx;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_on;
  logic       alarm_ack;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       pm;
  logic       sec_pulse;
  logic [1:0] alarm_hit;
  logic       chime;

  int checks = 0;
  int errors = 0;

`ifdef ENDER_CHIME_EN
  localparam logic CHIME_EXP = 1'b1;
`else
  localparam logic CHIME_EXP = 1'b0;
`endif

  ender_timekeeper #(.TICKS_PER_SEC(4), .NUM_ALARMS(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .hold(hold), .mode_12h(mode_12h),
    .btn_min(btn_min), .btn_hr(btn_hr),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hr(alarm_hr),
    .alarm_min(alarm_min), .alarm_on(alarm_on), .alarm_ack(alarm_ack),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .pm(pm),
    .sec_pulse(sec_pulse), .alarm_hit(alarm_hit), .chime(chime)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic hr_sel);
    if (hr_sel) btn_hr = 1'b1;
    else        btn_min = 1'b1;
    repeat (2) @(negedge clk);
    btn_hr  = 1'b0;
    btn_min = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wr_alarm(input logic idx, input logic [4:0] h, input logic [5:0] m, input logic on);
    alarm_idx = idx;
    alarm_hr  = h;
    alarm_min = m;
    alarm_on  = on;
    alarm_wr  = 1'b1;
    @(negedge clk);
    alarm_wr  = 1'b0;
  endtask

  task automatic check_time(input string tag, input logic [23:0] exp);
    check(tag, {hour_bcd, min_bcd, sec_bcd}, exp);
  endtask

  int pulses;
  int wide;
  logic prev_pulse;

  initial begin
    rst_n = 1'b1; ena = 1'b1; hold = 1'b0; mode_12h = 1'b0;
    btn_min = 1'b0; btn_hr = 1'b0; alarm_wr = 1'b0; alarm_idx = '0;
    alarm_hr = '0; alarm_min = '0; alarm_on = 1'b0; alarm_ack = 1'b0;

    // Reset state and a full minute of free running.
    #2 rst_n = 1'b0;
    #1;
    check_time("reset_time", 24'h000000);
    check("reset_pm", 32'(pm), 32'd0);
    check("reset_pulse", 32'(sec_pulse), 32'd0);
    check("reset_hit", 32'(alarm_hit), 32'd0);
    check("reset_chime", 32'(chime), 32'd0);
    mode_12h = 1'b1;
    #1;
    check("reset_hour_12h", 32'(hour_bcd), 32'h12);
    check("reset_pm_12h", 32'(pm), 32'd0);
    mode_12h = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0; wide = 0; prev_pulse = 1'b0;
    for (int i = 0; i < 240; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sec_pulse) pulses++;
      if (sec_pulse && prev_pulse) wide++;
      prev_pulse = sec_pulse;
    end
    check_time("run_240", 24'h000100);
    check("pulse_count", 32'(pulses), 32'd60);
    check("pulse_wide", 32'(wide), 32'd0);

    // Preload 23:59:59 through the buttons and roll over midnight.
    hold = 1'b1;
    do_reset();
    for (int i = 1; i <= 23; i++) begin
      press(1'b1);
      if (i == 12 || i == 13) begin
        mode_12h = 1'b1;
        #1;
        check(i == 12 ? "h12_noon" : "h12_13", 32'(hour_bcd), i == 12 ? 32'h12 : 32'h01);
        check(i == 12 ? "pm_noon" : "pm_13", 32'(pm), 32'd1);
        mode_12h = 1'b0;
      end
    end
    check("hour_23", 32'(hour_bcd), 32'h23);
    check("pm_24h", 32'(pm), 32'd0);
    mode_12h = 1'b1;
    #1;
    check("h12_23", 32'({pm, hour_bcd}), 32'h111);
    mode_12h = 1'b0;
    for (int i = 0; i < 59; i++) press(1'b0);
    check_time("preset_2359", 24'h235900);
    hold = 1'b0;
    run(236);
    check_time("at_235959", 24'h235959);
    run(4);
    check_time("midnight_wrap", 24'h000000);
    check("chime_hour", 32'(chime), 32'(CHIME_EXP));
    run(1);
    check("chime_one_cycle", 32'(chime), 32'd0);

    // Minute button landing on the tick cycle, then prescaler restart off-tick.
    do_reset();
    run(5);
    btn_min = 1'b1;
    run(2);
    check_time("pre_btn", 24'h000001);
    run(1);
    check_time("btn_on_tick", 24'h000100);
    check("btn_tick_nopulse", 32'(sec_pulse), 32'd0);
    btn_min = 1'b0;
    run(3);
    check("after_btn_sec", 32'(sec_bcd), 32'h00);
    run(1);
    check("first_tick_after_btn", 32'(sec_bcd), 32'h01);
    check("pulse_after_btn", 32'(sec_pulse), 32'd1);
    btn_min = 1'b1;
    run(1);
    btn_min = 1'b0;
    run(2);
    check_time("btn_off_tick", 24'h000200);
    run(1);
    check("pre_restart", 32'(sec_bcd), 32'h00);
    run(3);
    check("tick_after_restart", 32'(sec_bcd), 32'h01);

    // Alarm channels: write filtering, tick-only firing, sticky until ack.
    hold = 1'b1;
    do_reset();
    wr_alarm(1'b1, 5'd0, 6'd2, 1'b1);
    wr_alarm(1'b1, 5'd24, 6'd2, 1'b1);
    wr_alarm(1'b1, 5'd0, 6'd60, 1'b1);
    wr_alarm(1'b0, 5'd0, 6'd3, 1'b1);
    press(1'b0);
    check_time("alarm_preset", 24'h000100);
    hold = 1'b0;
    run(239);
    check_time("alarm_before", 24'h000159);
    check("hit_before", 32'(alarm_hit), 32'd0);
    run(1);
    check_time("alarm_time", 24'h000200);
    check("hit_set", 32'(alarm_hit), 32'b10);
    run(6);
    check("hit_sticky", 32'(alarm_hit), 32'b10);
    alarm_ack = 1'b1;
    run(1);
    alarm_ack = 1'b0;
    check("hit_ack", 32'(alarm_hit), 32'd0);
    hold = 1'b1;
    press(1'b0);
    check_time("btn_to_alarm0", 24'h000300);
    check("btn_no_hit", 32'(alarm_hit), 32'd0);

    // Enable freeze, then asynchronous reset mid-count.
    hold = 1'b0;
    do_reset();
    run(146);
    check("sec_36", 32'(sec_bcd), 32'h36);
    ena = 1'b0;
    run(10);
    check("ena_freeze", 32'(sec_bcd), 32'h36);
    ena = 1'b1;
    run(2);
    check("sec_37", 32'(sec_bcd), 32'h37);
    check("pulse_37", 32'(sec_pulse), 32'd1);
    mode_12h = 1'b1;
    rst_n = 1'b0;
    #1;
    check_time("async_rst_time", 24'h120000);
    check("async_rst_pm", 32'(pm), 32'd0);
    check("async_rst_pulse", 32'(sec_pulse), 32'd0);
    check("async_rst_chime", 32'(chime), 32'd0);
    mode_12h = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(3);
    check("resume_no_tick", 32'(sec_bcd), 32'h00);
    run(1);
    check("resume_first_tick", 32'(sec_bcd), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ender_timekeeper.md
ENDER_TIMEKEEPER -- requirements
Module: ender_timekeeper

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 10_000_000, clk cycles per second (>=2).
REQ-002 SHALL have parameter NUM_ALARMS, default 2, number of alarm channels (1..4).
REQ-003 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: ena  in  1  global enable; hold  in  1  freeze timekeeping; mode_12h  in  1  display format.
REQ-005 SHALL have ports: btn_min, btn_hr  in  1 each  raw asynchronous set buttons, active-high.
REQ-006 SHALL have ports: alarm_wr  in  1; alarm_idx  in  $clog2(NUM_ALARMS) (min 1); alarm_hr  in  5 (binary 0-23); alarm_min  in  6 (binary 0-59); alarm_on  in  1; alarm_ack  in  1.
REQ-007 SHALL have ports: hour_bcd, min_bcd, sec_bcd  out  8 each; pm  out  1; sec_pulse  out  1; alarm_hit  out  NUM_ALARMS; chime  out  1.

Function
REQ-008 SHALL count prescaler 0..TICKS_PER_SEC-1 while ena=1 and hold=0; terminal count produces a one-cycle tick and wraps to 0.
REQ-009 SHALL pulse sec_pulse high for exactly the tick cycle.
REQ-010 SHALL hold time internally as BCD: seconds 00-59, minutes 00-59, hours 00-23; tick increments seconds, 59->00 carries to minutes, minutes 59->00 carries to hours, hours 23->00.
REQ-011 SHALL register every count update; outputs reflect the new value the cycle after the tick.
REQ-012 SHALL pass btn_min/btn_hr through a two-flop synchroniser plus rising-edge detect; an increment takes effect 3 clk cycles after the pin rises.
REQ-013 SHALL on btn_min edge: minutes +1 mod 60 (no hour carry), seconds->00, prescaler->0.
REQ-014 SHALL on btn_hr edge: hours +1 mod 24, minutes/seconds unchanged.
REQ-015 SHALL, when a button edge and a tick coincide, apply the button and discard that tick; coincident btn_min and btn_hr edges both apply.
REQ-016 SHALL honour buttons when hold=1 or ena=0; prescaler and tick frozen in both cases.
REQ-017 SHALL in mode_12h=0 output hour_bcd = internal 00-23, pm = 0.
REQ-018 SHALL in mode_12h=1 output hour 0->12, 1-11 unchanged, 12->12, 13-23 -> h-12; pm=1 iff internal hour>=12; combinational from state.
REQ-019 SHALL on alarm_wr write alarm entry alarm_idx; writes with idx>=NUM_ALARMS, hr>23 or min>59 are ignored.
REQ-020 SHALL set sticky alarm_hit[i] on the tick that makes time equal alarm i hh:mm:00 with entry enabled; button-induced matches do not fire.
REQ-021 SHALL clear all alarm_hit bits on alarm_ack; set in the same cycle as ack wins.

Reset
REQ-022 SHALL on rst_n low asynchronously clear: time 00:00:00, prescaler 0, synchroniser/edge flops 0, alarm entries 00:00 disabled, alarm_hit 0, sec_pulse 0, chime 0; hour_bcd = 8'h12 if mode_12h else 8'h00, pm 0.
REQ-023 SHALL resume counting on the first clk edge after rst_n deasserts; reset mid-second discards the partial second.

Configuration
REQ-024 SHALL with macro ENDER_CHIME_EN defined pulse chime for one cycle on the tick where minutes wrap 59->00 (hourly), not on button-induced wraps.
REQ-025 SHALL without ENDER_CHIME_EN tie chime to 0 and instantiate no chime logic.

Structure
REQ-026 SHALL place BCD digit typedef, limits (SEC_MAX=59, MIN_MAX=59, HR_MAX=23) and the 12h conversion function in package ender_clock_pkg.
REQ-027 SHALL use sub-module ender_bcd_counter (two-digit BCD, parameter MAX, inc/clear inputs, carry output) for seconds, minutes and hours.

Verification (TICKS_PER_SEC=4)
REQ-028 Reset then 240 cycles -> time 00:01:00, sec_pulse seen 60 times, each one cycle wide.
REQ-029 Preload 23:59:59 via buttons, one tick -> 00:00:00; with ENDER_CHIME_EN chime=1 one cycle, else 0.
REQ-030 mode_12h=1 at internal 00, 12, 13 -> hour_bcd 8'h12/pm0, 8'h12/pm1, 8'h01/pm1.
REQ-031 btn_min rise landing on the tick cycle -> minutes+1, seconds 00, no second advance, prescaler restarted.
REQ-032 Alarm 1 set 00:02 on -> alarm_hit=2'b10 at tick to 00:02:00, stays set until alarm_ack; write idx 1 with hr=24 -> ignored.
REQ-033 rst_n pulsed low mid-count at 00:00:37 -> all outputs return to reset values immediately, without a clk edge.
